// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: FSM states, store entry layout and
// pointer sizing helper.
package mau_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StLdReq,
      StLdWait
   } mau_state_e;

   localparam int unsigned MauAddrW = 16;
   localparam int unsigned MauDataW = 16;

   // Entry layout at the default widths; the FIFO builds the same shape from its parameters.
   typedef struct packed {
      logic [MauAddrW-1:0] addr;
      logic [MauDataW-1:0] data;
   } sb_entry_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Store buffer: SB_DEPTH-entry FIFO of {addr, data} with head read.
// With MAU_SB_FWD_EN an address-match port returns the youngest matching entry.
module store_buffer_fifo
   import mau_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned SB_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W-1:0] head_addr_o,
   output logic [DATA_W-1:0] head_data_o
`ifdef MAU_SB_FWD_EN
   ,
   input  logic [ADDR_W-1:0] match_addr_i,
   output logic              match_hit_o,
   output logic [DATA_W-1:0] match_data_o
`endif
);

   localparam int unsigned PtrW = ptr_w(SB_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t          mem_q [SB_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(SB_DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   assign head_addr_o = mem_q[rd_ptr_q].addr;
   assign head_data_o = mem_q[rd_ptr_q].data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload needs no reset: only entries below count_q are ever observed.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q].addr <= push_addr_i;
         mem_q[wr_ptr_q].data <= push_data_i;
      end
   end

`ifdef MAU_SB_FWD_EN
   // Walk oldest to youngest so the last hit wins.
   always_comb begin
      match_hit_o  = 1'b0;
      match_data_o = '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         if (CntW'(i) < count_q) begin
            if (mem_q[rd_ptr_q + PtrW'(i)].addr == match_addr_i) begin
               match_hit_o  = 1'b1;
               match_data_o = mem_q[rd_ptr_q + PtrW'(i)].data;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: buffered stores, handshaked loads, pipeline hold generation.
// Optional store-to-load forwarding is enabled by defining MAU_SB_FWD_EN.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned RD_W     = 4,
   parameter int unsigned SB_DEPTH = 4
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_memread,
   input  logic              ex_memwrite,
   input  logic              ex_regwrite,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [RD_W-1:0]   ex_rd,
   output logic              hold,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   mau_state_e        state_q, state_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_regwrite_q, wb_regwrite_d;
   logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic              is_load, is_store, ld_done, ld_may_issue;
   logic              hold_int, accept;
   logic              sb_push, sb_pop, sb_full, sb_empty;
   logic [ADDR_W-1:0] sb_head_addr;
   logic [DATA_W-1:0] sb_head_data;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   store_buffer_fifo #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .SB_DEPTH (SB_DEPTH)
   ) u_sb (
      .clk_i       (clock),
      .rst_ni      (rst),
      .push_i      (sb_push),
      .push_addr_i (ex_addr),
      .push_data_i (ex_wdata),
      .pop_i       (sb_pop),
      .full_o      (sb_full),
      .empty_o     (sb_empty),
      .head_addr_o (sb_head_addr),
      .head_data_o (sb_head_data)
`ifdef MAU_SB_FWD_EN
      ,
      .match_addr_i (ex_addr),
      .match_hit_o  (fwd_hit),
      .match_data_o (fwd_data)
`endif
   );

`ifdef MAU_SB_FWD_EN
   assign ld_may_issue = 1'b1;
`else
   assign fwd_hit      = 1'b0;
   assign fwd_data     = '0;
   assign ld_may_issue = sb_empty;
`endif

   assign is_load  = ex_valid & ex_memread;
   assign is_store = ex_valid & ex_memwrite & ~ex_memread;
   assign ld_done  = (state_q == StLdWait) & mem_rvalid;

   // A load releases the pipeline in its rvalid cycle so it retires on that edge.
   assign hold_int = (is_store & sb_full) | (is_load & ~fwd_hit & ~ld_done);
   assign hold     = rst & hold_int;
   assign accept   = ex_valid & ~hold_int;
   assign sb_push  = accept & is_store;

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      sb_pop    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (is_load && !fwd_hit && ld_may_issue) begin
               state_d = StLdReq;
            end else if (!sb_empty || sb_push) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sb_head_addr;
            mem_wdata = sb_head_data;
            if (mem_ready) begin
               sb_pop  = 1'b1;
               state_d = StIdle;
            end
         end
         StLdReq: begin
            mem_req  = 1'b1;
            mem_addr = ex_addr;
            if (mem_ready) state_d = StLdWait;
         end
         StLdWait: begin
            if (mem_rvalid) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wb_valid_d    = 1'b0;
      wb_regwrite_d = 1'b0;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      if (accept) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = ex_rd;
         wb_data_d  = DATA_W'(ex_addr);
         if (is_load) begin
            wb_regwrite_d = ex_regwrite;
            wb_data_d     = fwd_hit ? fwd_data : mem_rdata;
         end else if (!is_store) begin
            wb_regwrite_d = ex_regwrite;
         end
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         wb_valid_q    <= 1'b0;
         wb_regwrite_q <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         wb_valid_q    <= wb_valid_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
      end
   end

   assign wb_valid    = wb_valid_q;
   assign wb_regwrite = wb_regwrite_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;

endmodule
